// File: rtl/tl_pkg.sv
// Shared traffic-light definitions: debounce state encoding and light codes
// used by the light FSM and the sensor conditioner.
package tl_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RISE = 2'd1,
    S_HELD = 2'd2,
    S_FALL = 2'd3
  } deb_state_t;

  // Light codes as {GRN, YLW, RED}.
  localparam logic [2:0] LIGHT_GRN = 3'b100;
  localparam logic [2:0] LIGHT_YLW = 3'b010;
  localparam logic [2:0] LIGHT_RED = 3'b001;

  function automatic logic is_one_hot(input logic [2:0] lights);
    return (lights == LIGHT_GRN) || (lights == LIGHT_YLW) || (lights == LIGHT_RED);
  endfunction

endpackage

// File: rtl/car_sensor_conditioner_if.sv
// Bundle between the sensor conditioner and the light FSM: raw loop input,
// light acknowledge levels, and the conditioned request/count/fault outputs.
interface car_sensor_conditioner_if #(
  parameter int CNT_W = 4
);
  logic             sns_raw;
  logic             grn;
  logic             ylw;
  logic             red;
  logic             car;
  logic [CNT_W-1:0] car_cnt;
  logic             fault;

  modport master (
    output sns_raw, grn, ylw, red,
    input  car, car_cnt, fault
  );

  modport slave (
    input  sns_raw, grn, ylw, red,
    output car, car_cnt, fault
  );
endinterface

// File: rtl/car_sensor_conditioner_sync2.sv
// Two-flop synchroniser for a single asynchronous level input; also meant for
// the pedestrian button.
module sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/car_sensor_conditioner.sv
// Conditions the side-road vehicle loop: synchronise, debounce, count vehicles
// arriving under main-road green, and hold CAR until the controller leaves GRN.
module car_sensor_conditioner
  import tl_pkg::*;
#(
  parameter int DEB_ON  = 3,
  parameter int DEB_OFF = 2,
  parameter int CNT_W   = 4
) (
  input logic                      clk,
  input logic                      rst,
  car_sensor_conditioner_if.slave  bus
);

  localparam int DEB_MAX = (DEB_ON > DEB_OFF) ? DEB_ON : DEB_OFF;
  localparam int DEB_W   = (DEB_MAX < 2) ? 1 : $clog2(DEB_MAX);
  localparam logic [DEB_W-1:0] ON_LAST  = DEB_W'(DEB_ON - 1);
  localparam logic [DEB_W-1:0] OFF_LAST = DEB_W'(DEB_OFF - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  logic             sns_s;
  deb_state_t       state_q, state_d;
  logic [DEB_W-1:0] deb_cnt_q, deb_cnt_d;
  logic             arrive_q, arrive_d;
  logic             grn_q;
  logic             bad_q;
  logic             fault_q, fault_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             car_q, car_d;
  logic             ack;
  logic             bad;

  sync2 u_sync (
    .clk (clk),
    .rst (rst),
    .d   (bus.sns_raw),
    .q   (sns_s)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      deb_cnt_q <= '0;
      arrive_q  <= 1'b0;
      grn_q     <= 1'b0;
      bad_q     <= 1'b0;
      fault_q   <= 1'b0;
      cnt_q     <= '0;
      car_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      deb_cnt_q <= deb_cnt_d;
      arrive_q  <= arrive_d;
      grn_q     <= bus.grn;
      bad_q     <= bad;
      fault_q   <= fault_d;
      cnt_q     <= cnt_d;
      car_q     <= car_d;
    end
  end

  // Debounce: deb_cnt counts qualifying cycles already seen in RISE/FALL;
  // a glitch back to high during FALL re-enters HELD without a new arrival.
  always_comb begin
    state_d   = state_q;
    deb_cnt_d = deb_cnt_q;
    arrive_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (sns_s) begin
          if (DEB_ON == 1) begin
            state_d  = S_HELD;
            arrive_d = 1'b1;
          end else begin
            state_d   = S_RISE;
            deb_cnt_d = DEB_W'(1);
          end
        end
      end
      S_RISE: begin
        if (!sns_s) begin
          state_d = S_IDLE;
        end else if (deb_cnt_q == ON_LAST) begin
          state_d  = S_HELD;
          arrive_d = 1'b1;
        end else begin
          deb_cnt_d = deb_cnt_q + DEB_W'(1);
        end
      end
      S_HELD: begin
        if (!sns_s) begin
          if (DEB_OFF == 1) begin
            state_d = S_IDLE;
          end else begin
            state_d   = S_FALL;
            deb_cnt_d = DEB_W'(1);
          end
        end
      end
      S_FALL: begin
        if (sns_s) begin
          state_d = S_HELD;
        end else if (deb_cnt_q == OFF_LAST) begin
          state_d = S_IDLE;
        end else begin
          deb_cnt_d = deb_cnt_q + DEB_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign ack     = grn_q & ~bus.grn;
  assign bad     = ~is_one_hot({bus.grn, bus.ylw, bus.red});
  assign fault_d = fault_q | (bad & bad_q);

  // Ack wins over a same-cycle arrival: that vehicle is served by the phase
  // the controller is entering. A latched fault freezes the count.
  always_comb begin
    cnt_d = cnt_q;
    if (!fault_q) begin
      if (ack) begin
        cnt_d = '0;
      end else if (arrive_q && bus.grn && (cnt_q != CNT_MAX)) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
    car_d = (cnt_d != '0) & ~fault_d;
  end

  assign bus.car     = car_q;
  assign bus.car_cnt = cnt_q;
  assign bus.fault   = fault_q;

endmodule

// File: tb/tb_car_sensor_conditioner.sv
// Directed bench for car_sensor_conditioner: a CNT_W=4 instance plus a CNT_W=2
// instance sharing the same stimulus for the saturation case.
module tb_car_sensor_conditioner;
  import tl_pkg::*;

  logic clk;
  logic rst;
  logic sns_raw;
  logic grn, ylw, red;

  int total;
  int bad;

  car_sensor_conditioner_if #(.CNT_W(4)) bus4 ();
  car_sensor_conditioner_if #(.CNT_W(2)) bus2 ();

  assign bus4.sns_raw = sns_raw;
  assign bus4.grn     = grn;
  assign bus4.ylw     = ylw;
  assign bus4.red     = red;
  assign bus2.sns_raw = sns_raw;
  assign bus2.grn     = grn;
  assign bus2.ylw     = ylw;
  assign bus2.red     = red;

  car_sensor_conditioner #(.DEB_ON(3), .DEB_OFF(2), .CNT_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus4.slave)
  );

  car_sensor_conditioner #(.DEB_ON(3), .DEB_OFF(2), .CNT_W(2)) dut_sat (
    .clk (clk),
    .rst (rst),
    .bus (bus2.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_lights(input logic [2:0] l);
    {grn, ylw, red} = l;
  endtask

  task automatic vehicle(input int high_cycles, input int low_cycles);
    sns_raw = 1'b1;
    step(high_cycles);
    sns_raw = 1'b0;
    step(low_cycles);
  endtask

  // GRN falling edge clears the pending count, then the light returns to green.
  task automatic clear_phase();
    set_lights(LIGHT_YLW);
    step(1);
    set_lights(LIGHT_RED);
    step(1);
    set_lights(LIGHT_GRN);
    step(1);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    sns_raw = 1'b0;
    set_lights(LIGHT_GRN);
    for (int i = 0; i < 6; i++) begin
      sns_raw = ~sns_raw;
      step(1);
      total++;
      if (bus4.car !== 1'b0 || bus4.car_cnt !== 4'd0 || bus4.fault !== 1'b0) begin
        bad++;
        $display("[TB] FAIL reset_hold[%0d]: actual car=%b cnt=%0d fault=%b required 0/0/0",
                 i, bus4.car, bus4.car_cnt, bus4.fault);
      end
    end
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      sns_raw = ~sns_raw;
      step(1);
      total++;
      if (bus4.car !== 1'b0 || bus4.car_cnt !== 4'd0 || bus4.fault !== 1'b0) begin
        bad++;
        $display("[TB] FAIL reset_release[%0d]: actual car=%b cnt=%0d fault=%b required 0/0/0",
                 i, bus4.car, bus4.car_cnt, bus4.fault);
      end
    end
    sns_raw = 1'b0;
    step(4);
  endtask

  task automatic test_single_vehicle();
    sns_raw = 1'b1;
    step(5);
    total++;
    if (bus4.car_cnt !== 4'd0 || bus4.car !== 1'b0) begin
      bad++;
      $display("[TB] FAIL latency_early: actual cnt=%0d car=%b required 0/0", bus4.car_cnt, bus4.car);
    end
    sns_raw = 1'b0;
    step(1);
    total++;
    if (bus4.car_cnt !== 4'd1 || bus4.car !== 1'b1) begin
      bad++;
      $display("[TB] FAIL latency_k5: actual cnt=%0d car=%b required 1/1", bus4.car_cnt, bus4.car);
    end
    step(6);
    total++;
    if (bus4.car_cnt !== 4'd1 || bus4.car !== 1'b1) begin
      bad++;
      $display("[TB] FAIL hold_green: actual cnt=%0d car=%b required 1/1", bus4.car_cnt, bus4.car);
    end
  endtask

  task automatic test_debounce();
    clear_phase();
    total++;
    if (bus4.car_cnt !== 4'd0 || bus4.car !== 1'b0) begin
      bad++;
      $display("[TB] FAIL clear_ack: actual cnt=%0d car=%b required 0/0", bus4.car_cnt, bus4.car);
    end
    vehicle(2, 6);
    total++;
    if (bus4.car_cnt !== 4'd0 || bus4.car !== 1'b0) begin
      bad++;
      $display("[TB] FAIL short_pulse: actual cnt=%0d car=%b required 0/0", bus4.car_cnt, bus4.car);
    end
    sns_raw = 1'b1;
    step(4);
    sns_raw = 1'b0;
    step(1);
    sns_raw = 1'b1;
    step(5);
    sns_raw = 1'b0;
    step(6);
    total++;
    if (bus4.car_cnt !== 4'd1 || bus4.car !== 1'b1) begin
      bad++;
      $display("[TB] FAIL glitch_single: actual cnt=%0d car=%b required 1/1", bus4.car_cnt, bus4.car);
    end
  endtask

  task automatic test_multi_and_ack();
    clear_phase();
    for (int i = 0; i < 3; i++) vehicle(4, 5);
    total++;
    if (bus4.car_cnt !== 4'd3 || bus4.car !== 1'b1) begin
      bad++;
      $display("[TB] FAIL three_vehicles: actual cnt=%0d car=%b required 3/1", bus4.car_cnt, bus4.car);
    end
    set_lights(LIGHT_YLW);
    step(1);
    total++;
    if (bus4.car_cnt !== 4'd0 || bus4.car !== 1'b0) begin
      bad++;
      $display("[TB] FAIL ack_clear: actual cnt=%0d car=%b required 0/0", bus4.car_cnt, bus4.car);
    end
    vehicle(4, 5);
    total++;
    if (bus4.car_cnt !== 4'd0) begin
      bad++;
      $display("[TB] FAIL yellow_ignored: actual cnt=%0d required 0", bus4.car_cnt);
    end
    set_lights(LIGHT_RED);
    vehicle(4, 5);
    total++;
    if (bus4.car_cnt !== 4'd0 || bus4.car !== 1'b0) begin
      bad++;
      $display("[TB] FAIL red_ignored: actual cnt=%0d car=%b required 0/0", bus4.car_cnt, bus4.car);
    end
    set_lights(LIGHT_GRN);
    step(2);
    total++;
    if (bus4.car_cnt !== 4'd0) begin
      bad++;
      $display("[TB] FAIL green_return: actual cnt=%0d required 0", bus4.car_cnt);
    end
  endtask

  task automatic test_saturate_and_coincide();
    clear_phase();
    for (int i = 0; i < 5; i++) vehicle(4, 5);
    total++;
    if (bus4.car_cnt !== 4'd5) begin
      bad++;
      $display("[TB] FAIL five_wide: actual cnt=%0d required 5", bus4.car_cnt);
    end
    total++;
    if (bus2.car_cnt !== 2'd3 || bus2.car !== 1'b1) begin
      bad++;
      $display("[TB] FAIL saturate: actual cnt=%0d car=%b required 3/1", bus2.car_cnt, bus2.car);
    end
    sns_raw = 1'b1;
    step(5);
    set_lights(LIGHT_YLW);
    step(1);
    total++;
    if (bus4.car_cnt !== 4'd0 || bus2.car_cnt !== 2'd0 || bus4.car !== 1'b0) begin
      bad++;
      $display("[TB] FAIL ack_with_arrive: actual cnt4=%0d cnt2=%0d car=%b required 0/0/0",
               bus4.car_cnt, bus2.car_cnt, bus4.car);
    end
    sns_raw = 1'b0;
    step(5);
    set_lights(LIGHT_RED);
    step(1);
    set_lights(LIGHT_GRN);
    step(2);
    total++;
    if (bus4.car_cnt !== 4'd0 || bus2.car_cnt !== 2'd0) begin
      bad++;
      $display("[TB] FAIL after_coincide: actual cnt4=%0d cnt2=%0d required 0/0",
               bus4.car_cnt, bus2.car_cnt);
    end
  endtask

  task automatic test_fault_and_reset();
    vehicle(4, 5);
    total++;
    if (bus4.car_cnt !== 4'd1 || bus4.car !== 1'b1) begin
      bad++;
      $display("[TB] FAIL pre_fault: actual cnt=%0d car=%b required 1/1", bus4.car_cnt, bus4.car);
    end
    ylw = 1'b1;
    step(1);
    ylw = 1'b0;
    step(3);
    total++;
    if (bus4.fault !== 1'b0 || bus4.car !== 1'b1) begin
      bad++;
      $display("[TB] FAIL single_bad_cycle: actual fault=%b car=%b required 0/1", bus4.fault, bus4.car);
    end
    ylw = 1'b1;
    step(1);
    total++;
    if (bus4.fault !== 1'b0) begin
      bad++;
      $display("[TB] FAIL fault_early: actual fault=%b required 0", bus4.fault);
    end
    step(1);
    total++;
    if (bus4.fault !== 1'b1 || bus4.car !== 1'b0 || bus4.car_cnt !== 4'd1) begin
      bad++;
      $display("[TB] FAIL fault_set: actual fault=%b car=%b cnt=%0d required 1/0/1",
               bus4.fault, bus4.car, bus4.car_cnt);
    end
    set_lights(LIGHT_GRN);
    vehicle(4, 5);
    set_lights(LIGHT_YLW);
    step(2);
    total++;
    if (bus4.fault !== 1'b1 || bus4.car !== 1'b0 || bus4.car_cnt !== 4'd1) begin
      bad++;
      $display("[TB] FAIL fault_sticky: actual fault=%b car=%b cnt=%0d required 1/0/1",
               bus4.fault, bus4.car, bus4.car_cnt);
    end
    set_lights(LIGHT_GRN);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    total++;
    if (bus4.fault !== 1'b0 || bus4.car !== 1'b0 || bus4.car_cnt !== 4'd0) begin
      bad++;
      $display("[TB] FAIL async_reset: actual fault=%b car=%b cnt=%0d required 0/0/0",
               bus4.fault, bus4.car, bus4.car_cnt);
    end
    #2;
    rst = 1'b0;
    step(3);
    total++;
    if (bus4.fault !== 1'b0 || bus4.car !== 1'b0 || bus4.car_cnt !== 4'd0) begin
      bad++;
      $display("[TB] FAIL post_reset: actual fault=%b car=%b cnt=%0d required 0/0/0",
               bus4.fault, bus4.car, bus4.car_cnt);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_single_vehicle();
    test_debounce();
    test_multi_and_ack();
    test_saturate_and_coincide();
    test_fault_and_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
